hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised Tuse/Tnew hazard controller for the five-stage MIPS pipeline, sitting beside the D stage. It keeps a shift-register scoreboard of in-flight destination registers and their remaining Tnew for the stages after D. It combines that with a multiply/divide busy counter to drive a single D-stage stall, and it reports which stage each source operand should be forwarded from. It replaces per-stage hard-coded Tnew comparisons with a depth- and latency-configurable block.

## Interface
- STAGES, 3, number of tracked stages after D (slot 0 = E, 1 = M, 2 = W, …)
- TW, 2, width of Tuse/Tnew fields
- RAW, 5, register address width
- MULT_CYC, 5, busy cycles loaded on a multiply start
- DIV_CYC, 10, busy cycles loaded on a divide start
- SW, $clog2(STAGES) (minimum 1), width of forward stage index
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears scoreboard and md counter
- flush  in  1  synchronous; invalidates all scoreboard slots (exception/eret)
- d_valid  in  1  D stage holds a real instruction
- d_rs, d_rt  in  RAW  D source register addresses
- d_rs_tuse, d_rt_tuse  in  TW  cycles until D needs the operand; value 3 means unused
- d_wen  in  1  D instruction writes the GRF
- d_waddr  in  RAW  D destination register
- d_tnew  in  TW  Tnew the instruction will have on entering E (ALU=1, load=2, link=0)
- d_md_use  in  1  D is mult/div/mfhi/mflo/mthi/mtlo
- e_md_start  in  1  E stage is starting mult/div this cycle
- e_md_div  in  1  qualifier for e_md_start: 1 = divide
- stall  out  1  freeze PC/F/D and insert a bubble into E
- fwd_rs_hit, fwd_rt_hit  out  1  operand available now from a tracked stage
- fwd_rs_stage, fwd_rt_stage  out  SW  slot index to forward from (valid when hit)
- md_busy  out  1  md counter nonzero

## Operation
- Slot i holds {valid, waddr, tnew}. Slot 0 holds the instruction currently in E.
- Match(src, i) = slot i valid & waddr == src & src != 0.
- Per source, the youngest matching slot (lowest i) is authoritative. Older matches are ignored.
- Data stall per source: youngest match exists, its tnew > tuse, and tuse != 3.
- Forward: youngest match exists with tnew == 0 → hit = 1, stage = i. Otherwise hit = 0 and stage = 0.
- A youngest match with 0 < tnew ≤ tuse produces neither stall nor hit. Forwarding happens in a later cycle.
- MD stall: d_md_use & (md_busy | e_md_start).
- stall = d_valid & (rs data stall | rt data stall | MD stall). It is combinational from state and D inputs.
- Scoreboard update on each posedge:
  - If reset or flush: all slots invalid.
  - Otherwise slot 0 gets {d_valid & d_wen & d_waddr != 0 & ~stall, d_waddr, d_tnew}. A stall inserts a bubble (valid = 0).
  - Slot i>0 gets slot i−1 with tnew = max(tnew−1, 0). The last slot's contents drop out.
- MD counter update on each posedge:
  - If reset: 0.
  - Else if e_md_start: load DIV_CYC when e_md_div, otherwise MULT_CYC. A start while busy reloads the counter.
  - Else if nonzero: decrement.
  - flush does not affect the counter.
- Width rules: tnew saturates at 0 and never wraps. Register 0 never matches, stalls or forwards.

## Timing
- Reset values: all slots invalid, md counter 0, md_busy 0. After reset, stall is 1 only when d_valid & d_md_use & e_md_start.
- All outputs are combinational from registered state plus current inputs, with zero-cycle latency. The scoreboard reflects a D instruction one cycle after it leaves D.
- Load-use (tnew 2 vs tuse 1) stalls exactly 1 cycle. An ALU result in E feeding a branch (tnew 1 vs tuse 0) stalls exactly 1 cycle.
- md_busy stays high for exactly MULT_CYC or DIV_CYC cycles after the start edge. The start cycle itself stalls through e_md_start.
- A flush asserted together with a stall: the flush wins and all slots are invalid next cycle.
- reset and flush have the same effect on slots. Only reset clears the md counter.

## Test plan
- lw $8 in D (d_tnew=2), then add $9,$8,$1 in D (rs_tuse 1) → stall=1 for one cycle; next cycle stall=0, fwd_rs_hit=0; following cycle with $8 in W slot (tnew 0) → fwd_rs_hit=1, fwd_rs_stage=2.
- addu $3 in E (tnew 1), beq $3,$0 in D (tuse 0) → stall=1 one cycle, then fwd_rs_hit=1 from stage 1.
- Writes to $0 with d_tnew=2 followed by a consumer of $0 → stall never asserts and hit stays 0.
- Two writers to $5 in slots 0 (tnew 1) and 2 (tnew 0), sw with rt=$5 (tuse 2) → stall=0, hit=0 (youngest match wins, not stage 2).
- mult in E (e_md_start=1, e_md_div=0), mflo in D → stall for the start cycle plus 5 busy cycles; with e_md_div=1 → 1+10 cycles.
- Load in slot 0 with a dependent add in D, flush asserted → next cycle all slots invalid and stall=0. A reset mid-divide → md_busy=0 the next cycle.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard controller beside the D stage: tracks in-flight destinations
// per pipeline slot, drives the D-stage stall and reports forwarding sources.
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int TW       = 2,
  parameter int RAW      = 5,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           d_valid,
  input  logic [RAW-1:0] d_rs,
  input  logic [RAW-1:0] d_rt,
  input  logic [TW-1:0]  d_rs_tuse,
  input  logic [TW-1:0]  d_rt_tuse,
  input  logic           d_wen,
  input  logic [RAW-1:0] d_waddr,
  input  logic [TW-1:0]  d_tnew,
  input  logic           d_md_use,
  input  logic           e_md_start,
  input  logic           e_md_div,
  output logic           stall,
  output logic           fwd_rs_hit,
  output logic           fwd_rt_hit,
  output logic [SW-1:0]  fwd_rs_stage,
  output logic [SW-1:0]  fwd_rt_stage,
  output logic           md_busy
);

  localparam int CMAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [TW-1:0] TUSE_NONE = TW'(3);

  typedef struct packed {
    logic          found;
    logic [SW-1:0] idx;
    logic [TW-1:0] tnew;
  } lookup_t;

  logic [STAGES-1:0]          valid_q, valid_d;
  logic [STAGES-1:0][RAW-1:0] waddr_q, waddr_d;
  logic [STAGES-1:0][TW-1:0]  tnew_q, tnew_d;
  logic [CW-1:0]              mdCnt_q, mdCnt_d;

  lookup_t rsLook, rtLook;
  logic    rsStall, rtStall, mdStall;

  // Scan oldest to youngest so the lowest matching slot overrides older ones.
  function automatic lookup_t youngest(input logic [RAW-1:0] src,
                                       input logic [STAGES-1:0] v,
                                       input logic [STAGES-1:0][RAW-1:0] wa,
                                       input logic [STAGES-1:0][TW-1:0] tn);
    lookup_t r;
    r = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (v[i] && (wa[i] == src) && (src != '0)) begin
        r.found = 1'b1;
        r.idx   = SW'(i);
        r.tnew  = tn[i];
      end
    end
    return r;
  endfunction

  always_comb begin
    rsLook  = youngest(d_rs, valid_q, waddr_q, tnew_q);
    rtLook  = youngest(d_rt, valid_q, waddr_q, tnew_q);
    rsStall = rsLook.found && (rsLook.tnew > d_rs_tuse) && (d_rs_tuse != TUSE_NONE);
    rtStall = rtLook.found && (rtLook.tnew > d_rt_tuse) && (d_rt_tuse != TUSE_NONE);
    md_busy = (mdCnt_q != '0);
    mdStall = d_md_use && (md_busy || e_md_start);
    stall   = d_valid && (rsStall || rtStall || mdStall);

    fwd_rs_hit   = rsLook.found && (rsLook.tnew == '0);
    fwd_rt_hit   = rtLook.found && (rtLook.tnew == '0);
    fwd_rs_stage = fwd_rs_hit ? rsLook.idx : '0;
    fwd_rt_stage = fwd_rt_hit ? rtLook.idx : '0;
  end

  // Slot 0 captures the leaving D instruction (a bubble on stall); older slots
  // shift down while their remaining Tnew counts toward zero without wrapping.
  always_comb begin
    valid_d    = '0;
    waddr_d    = '0;
    tnew_d     = '0;
    valid_d[0] = d_valid && d_wen && (d_waddr != '0) && !stall;
    waddr_d[0] = d_waddr;
    tnew_d[0]  = d_tnew;
    for (int i = 1; i < STAGES; i++) begin
      valid_d[i] = valid_q[i-1];
      waddr_d[i] = waddr_q[i-1];
      tnew_d[i]  = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
  end

  // A new start always reloads, even while a previous operation is still busy.
  always_comb begin
    mdCnt_d = mdCnt_q;
    if (e_md_start) begin
      mdCnt_d = e_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (mdCnt_q != '0) begin
      mdCnt_d = mdCnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    waddr_q <= waddr_d;
    tnew_q  <= tnew_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mdCnt_q <= '0;
    end else begin
      mdCnt_q <= mdCnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-cycle vector table for the
// scoreboard paths plus hand-written sequences for the mult/div busy counter.
module tb_hazard_scoreboard;

  localparam int STAGES = 3;
  localparam int TW     = 2;
  localparam int RAW    = 5;
  localparam int MULT   = 5;
  localparam int DIV    = 10;
  localparam int SW     = 2;
  localparam int NVEC   = 24;

  logic           clk = 1'b0;
  logic           reset, flush, dValid, dWen, dMdUse, eMdStart, eMdDiv;
  logic [RAW-1:0] dRs, dRt, dWaddr;
  logic [TW-1:0]  dRsTuse, dRtTuse, dTnew;
  logic           stall, fwdRsHit, fwdRtHit, mdBusy;
  logic [SW-1:0]  fwdRsStage, fwdRtStage;

  int compared   = 0;
  int mismatched = 0;
  int stallCycles;

  typedef struct {
    logic           rst, fl, dv;
    logic [RAW-1:0] rs;
    logic [TW-1:0]  rsTuse;
    logic [RAW-1:0] rt;
    logic [TW-1:0]  rtTuse;
    logic           wen;
    logic [RAW-1:0] waddr;
    logic [TW-1:0]  tnew;
    logic           expStall, expRsHit;
    logic [SW-1:0]  expRsStage;
    logic           expRtHit;
    logic [SW-1:0]  expRtStage;
    logic           expBusy;
  } vec_t;

  vec_t vecs [NVEC];

  hazard_scoreboard #(
    .STAGES(STAGES), .TW(TW), .RAW(RAW), .MULT_CYC(MULT), .DIV_CYC(DIV), .SW(SW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(dValid),
    .d_rs(dRs), .d_rt(dRt), .d_rs_tuse(dRsTuse), .d_rt_tuse(dRtTuse),
    .d_wen(dWen), .d_waddr(dWaddr), .d_tnew(dTnew), .d_md_use(dMdUse),
    .e_md_start(eMdStart), .e_md_div(eMdDiv), .stall(stall),
    .fwd_rs_hit(fwdRsHit), .fwd_rt_hit(fwdRtHit),
    .fwd_rs_stage(fwdRsStage), .fwd_rt_stage(fwdRtStage), .md_busy(mdBusy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int rst, fl, dv, rs, rsT, rt, rtT, wen, wa, tn,
                              input int st, rh, rsStg, th, rtStg, busy);
    vec_t v;
    v.rst = 1'(rst);  v.fl = 1'(fl);  v.dv = 1'(dv);
    v.rs = RAW'(rs);  v.rsTuse = TW'(rsT);
    v.rt = RAW'(rt);  v.rtTuse = TW'(rtT);
    v.wen = 1'(wen);  v.waddr = RAW'(wa);  v.tnew = TW'(tn);
    v.expStall = 1'(st);  v.expRsHit = 1'(rh);  v.expRsStage = SW'(rsStg);
    v.expRtHit = 1'(th);  v.expRtStage = SW'(rtStg);  v.expBusy = 1'(busy);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    flush    = v.fl;
    dValid   = v.dv;
    dRs      = v.rs;
    dRsTuse  = v.rsTuse;
    dRt      = v.rt;
    dRtTuse  = v.rtTuse;
    dWen     = v.wen;
    dWaddr   = v.waddr;
    dTnew    = v.tnew;
    dMdUse   = 1'b0;
    eMdStart = 1'b0;
    eMdDiv   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    reset = 1'b0;  flush = 1'b0;  dValid = 1'b0;
    dRs = '0;  dRt = '0;  dRsTuse = TW'(3);  dRtTuse = TW'(3);
    dWen = 1'b0;  dWaddr = '0;  dTnew = '0;
    dMdUse = 1'b0;  eMdStart = 1'b0;  eMdDiv = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //               rst fl dv  rs rsT rt rtT wen wa tn | st rh rsS th rtS busy
    vecs[0]  = mk(0, 0, 1,  8, 0,  9, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0);
    // load-use: lw $8, then add $9,$8,$1 stalls once, then forwards from W
    vecs[1]  = mk(0, 0, 1, 29, 1,  8, 3,  1,  8, 2,   0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 1,  8, 1,  1, 1,  1,  9, 1,   1, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 1,  8, 1,  1, 1,  1,  9, 1,   0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 1,  8, 1,  9, 1,  1, 10, 1,   0, 1, 2, 0, 0, 0);
    // addu $3 then beq $3,$0
    vecs[5]  = mk(0, 0, 1,  1, 1,  2, 1,  1,  3, 1,   0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1,  3, 0,  0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 1,  3, 0,  0, 0,  0,  0, 0,   0, 1, 1, 0, 0, 0);
    // writes to $0 never create hazards
    vecs[8]  = mk(0, 0, 1,  0, 1,  0, 1,  1,  0, 2,   0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(0, 0, 1,  0, 0,  0, 0,  1,  0, 2,   0, 0, 0, 0, 0, 0);
    // two writers of $5: youngest (tnew 1) shadows the older tnew-0 copy
    vecs[10] = mk(0, 0, 1,  1, 1,  2, 1,  1,  5, 2,   0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1,  1, 1,  2, 1,  1,  6, 1,   0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 1,  1, 1,  2, 1,  1,  5, 1,   0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 1, 29, 1,  5, 2,  0,  0, 0,   0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 1,  6, 1,  5, 2,  0,  0, 0,   0, 1, 2, 1, 1, 0);
    // flush during a load-use stall
    vecs[15] = mk(0, 0, 1, 29, 1,  8, 3,  1,  8, 2,   0, 0, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 1,  8, 1,  1, 1,  1,  9, 1,   1, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 1,  8, 1,  1, 1,  1,  9, 1,   0, 0, 0, 0, 0, 0);
    // rt-side stall then forward
    vecs[18] = mk(0, 0, 1,  1, 1,  9, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 0, 1,  1, 1,  9, 0,  0,  0, 0,   0, 0, 0, 1, 1, 0);
    // tuse 3 means unused: pending result does not stall
    vecs[20] = mk(0, 0, 1,  9, 3,  0, 0,  1,  7, 2,   0, 1, 2, 0, 0, 0);
    vecs[21] = mk(0, 0, 1,  7, 3,  0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0);
    // reset clears pending $7 (slot 1, tnew 1)
    vecs[22] = mk(1, 0, 1,  7, 0,  0, 0,  0,  0, 0,   1, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 1,  7, 0,  0, 0,  0,  0, 0,   0, 0, 0, 0, 0, 0);

    idleInputs();
    reset = 1'b1;
    @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d stall", i), 32'(stall), 32'(vecs[i].expStall));
      checkOutput($sformatf("row%0d rsHit", i), 32'(fwdRsHit), 32'(vecs[i].expRsHit));
      checkOutput($sformatf("row%0d rsStage", i), 32'(fwdRsStage), 32'(vecs[i].expRsStage));
      checkOutput($sformatf("row%0d rtHit", i), 32'(fwdRtHit), 32'(vecs[i].expRtHit));
      checkOutput($sformatf("row%0d rtStage", i), 32'(fwdRtStage), 32'(vecs[i].expRtStage));
      checkOutput($sformatf("row%0d busy", i), 32'(mdBusy), 32'(vecs[i].expBusy));
    end

    // mflo behind a mult: start cycle plus MULT busy cycles
    @(negedge clk);
    idleInputs();
    dValid = 1'b1;  dMdUse = 1'b1;  eMdStart = 1'b1;  eMdDiv = 1'b0;
    #1;
    checkOutput("mult start stall", 32'(stall), 32'd1);
    stallCycles = (stall === 1'b1) ? 1 : 0;
    @(negedge clk);
    eMdStart = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (stall !== 1'b1) break;
      stallCycles++;
      @(negedge clk);
    end
    checkOutput("mult stall cycles", 32'(stallCycles), 32'(1 + MULT));
    checkOutput("mult busy cleared", 32'(mdBusy), 32'd0);

    // same for a divide
    @(negedge clk);
    eMdStart = 1'b1;  eMdDiv = 1'b1;
    #1;
    checkOutput("div start stall", 32'(stall), 32'd1);
    stallCycles = (stall === 1'b1) ? 1 : 0;
    @(negedge clk);
    eMdStart = 1'b0;  eMdDiv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (stall !== 1'b1) break;
      stallCycles++;
      @(negedge clk);
    end
    checkOutput("div stall cycles", 32'(stallCycles), 32'(1 + DIV));

    // no stall without a valid D instruction; flush leaves counter alone
    @(negedge clk);
    dValid = 1'b0;  eMdStart = 1'b1;
    #1;
    checkOutput("invalid D md stall", 32'(stall), 32'd0);
    @(negedge clk);
    eMdStart = 1'b0;  flush = 1'b1;
    #1;
    checkOutput("busy after mult start", 32'(mdBusy), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("busy survives flush", 32'(mdBusy), 32'd1);

    // reset in the middle of a divide
    @(negedge clk);
    eMdStart = 1'b1;  eMdDiv = 1'b1;
    @(negedge clk);
    eMdStart = 1'b0;  eMdDiv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("busy mid divide", 32'(mdBusy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("busy after reset", 32'(mdBusy), 32'd0);
    dValid = 1'b1;  dMdUse = 1'b1;
    #1;
    checkOutput("no md stall after reset", 32'(stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
